// File: rtl/vending_machine_pkg.sv
// Shared vending-machine definitions: default coin set, widths, timing and the
// payout state type used by the change dispenser.
package vending_machine_pkg;

    localparam int kNumCoins  = 3;
    localparam int kTotalBits = 31;
    localparam int kInvBits   = 8;
    localparam int kWaitTime  = 100;

    // Index 0 is the smallest denomination; values strictly ascending.
    localparam logic [kNumCoins*32-1:0] kCoinValues = {32'd1000, 32'd500, 32'd100};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RETURN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: the largest denomination that fits the remaining
// balance and is still in stock.
module coin_select #(
    parameter int                      NUM_COINS   = 3,
    parameter int                      TOTAL_BITS  = 31,
    parameter int                      INV_BITS    = 8,
    parameter logic [NUM_COINS*32-1:0] COIN_VALUES = '0
) (
    input  logic [TOTAL_BITS-1:0]         remaining,
    input  logic [NUM_COINS*INV_BITS-1:0] inventory,
    output logic [NUM_COINS-1:0]          select,
    output logic                          found
);

    localparam int CMP_BITS = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;

    logic [CMP_BITS-1:0] remaining_ext;

    assign remaining_ext = CMP_BITS'(remaining);

    // Ascending scan: a later (larger) qualifying coin overrides an earlier one.
    always_comb begin
        select = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (remaining_ext >= CMP_BITS'(COIN_VALUES[k*32 +: 32]) &&
                inventory[k*INV_BITS +: INV_BITS] != '0) begin
                select    = '0;
                select[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return controller: owns the coin inventory and inactivity timer, and on a
// return request or timeout pays the latched balance out one coin per cycle.
module change_dispenser
    import vending_machine_pkg::*;
#(
    parameter int                               NUM_COINS   = kNumCoins,
    parameter int                               TOTAL_BITS  = kTotalBits,
    parameter int                               INV_BITS    = kInvBits,
    parameter int                               WAIT_TIME   = kWaitTime,
    parameter logic [NUM_COINS*32-1:0]          COIN_VALUES = kCoinValues,
    parameter logic [NUM_COINS*INV_BITS-1:0]    INIT_INV    = {NUM_COINS{INV_BITS'(4)}}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_COINS-1:0]          i_input_coin,
    input  logic                          i_item_dispensed,
    input  logic                          i_trigger_return,
    input  logic [TOTAL_BITS-1:0]         i_total,
    output logic [NUM_COINS-1:0]          o_return_coin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [TOTAL_BITS-1:0]         o_shortfall,
    output logic [31:0]                   o_wait_time,
    output logic [NUM_COINS*INV_BITS-1:0] o_inventory
);

    state_t                        state, state_next;
    logic [TOTAL_BITS-1:0]         remaining, remaining_next;
    logic [TOTAL_BITS-1:0]         shortfall_next;
    logic [TOTAL_BITS-1:0]         sel_value;
    logic [31:0]                   wait_next;
    logic [NUM_COINS-1:0]          coin_next;
    logic [NUM_COINS-1:0]          sel;
    logic                          found;
    logic                          start;
    logic [NUM_COINS*INV_BITS-1:0] inventory, inv_next;

    coin_select #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS),
        .INV_BITS   (INV_BITS),
        .COIN_VALUES(COIN_VALUES)
    ) u_coin_select (
        .remaining(remaining),
        .inventory(inventory),
        .select   (sel),
        .found    (found)
    );

    // The compare in coin_select guarantees the selected value fits the balance.
    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (sel[k]) begin
                sel_value = sel_value | TOTAL_BITS'(COIN_VALUES[k*32 +: 32]);
            end
        end
    end

    assign start = (i_trigger_return && i_total != '0) || (o_wait_time == 32'(WAIT_TIME));

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        shortfall_next = o_shortfall;
        wait_next      = o_wait_time;
        coin_next      = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    remaining_next = i_total;
                    shortfall_next = '0;
                    wait_next      = '0;
                    state_next     = ST_RETURN;
                end else if (|i_input_coin || i_item_dispensed) begin
                    wait_next = '0;
                end else if (i_total != '0 && o_wait_time < 32'(WAIT_TIME)) begin
                    wait_next = o_wait_time + 32'd1;
                end
            end
            ST_RETURN: begin
                wait_next = '0;
                if (found) begin
                    coin_next      = sel;
                    remaining_next = remaining - sel_value;
                end else begin
                    shortfall_next = remaining;
                    state_next     = ST_DONE;
                end
            end
            ST_DONE: begin
                wait_next  = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A deposit and a payout of the same coin in one cycle cancel out.
    always_comb begin
        inv_next = inventory;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (i_input_coin[j] && !coin_next[j]) begin
                if (inventory[j*INV_BITS +: INV_BITS] != {INV_BITS{1'b1}}) begin
                    inv_next[j*INV_BITS +: INV_BITS] = inventory[j*INV_BITS +: INV_BITS] + 1'b1;
                end
            end else if (coin_next[j] && !i_input_coin[j]) begin
                inv_next[j*INV_BITS +: INV_BITS] = inventory[j*INV_BITS +: INV_BITS] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            o_return_coin <= '0;
            o_shortfall   <= '0;
            o_wait_time   <= '0;
            inventory     <= INIT_INV;
        end else begin
            state         <= state_next;
            o_return_coin <= coin_next;
            o_shortfall   <= shortfall_next;
            o_wait_time   <= wait_next;
            inventory     <= inv_next;
        end
    end

    always_ff @(posedge clk) begin
        remaining <= remaining_next;
    end

    assign o_busy      = (state == ST_RETURN);
    assign o_done      = (state == ST_DONE);
    assign o_inventory = inventory;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: an integer-level payout model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_change_dispenser;

    localparam int NC   = 3;
    localparam int IB   = 8;
    localparam int TB   = 31;
    localparam int WAIT = 100;
    localparam longint VAL [NC] = '{100, 500, 1000};

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NC-1:0]   i_input_coin;
    logic            i_item_dispensed;
    logic            i_trigger_return;
    logic [TB-1:0]   i_total;
    logic [NC-1:0]   o_return_coin;
    logic            o_busy;
    logic            o_done;
    logic [TB-1:0]   o_shortfall;
    logic [31:0]     o_wait_time;
    logic [NC*IB-1:0] o_inventory;

    int n_checks = 0;
    int n_err    = 0;

    change_dispenser dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_input_coin    (i_input_coin),
        .i_item_dispensed(i_item_dispensed),
        .i_trigger_return(i_trigger_return),
        .i_total         (i_total),
        .o_return_coin   (o_return_coin),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_shortfall     (o_shortfall),
        .o_wait_time     (o_wait_time),
        .o_inventory     (o_inventory)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: phase 0 idle, 1 paying, 2 done. Greedy choice made from integers each cycle.
    int          m_phase;
    int          m_wait;
    int          m_inv [NC];
    longint      m_rem;
    longint      m_short;
    logic [NC-1:0] m_coin;
    bit          m_valid = 1'b0;
    int          pick;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase = 0;
            m_wait  = 0;
            m_short = 0;
            m_rem   = 0;
            m_coin  = '0;
            for (int j = 0; j < NC; j++) m_inv[j] = 4;
            m_valid = 1'b1;
        end else begin
            m_coin = '0;
            if (m_phase == 1) begin
                pick = -1;
                for (int k = 0; k < NC; k++)
                    if (VAL[k] <= m_rem && m_inv[k] > 0) pick = k;
                if (pick >= 0) begin
                    m_coin[pick] = 1'b1;
                    m_rem = m_rem - VAL[pick];
                end else begin
                    m_short = m_rem;
                    m_phase = 2;
                end
                m_wait = 0;
            end else if (m_phase == 2) begin
                m_phase = 0;
                m_wait  = 0;
            end else begin
                if ((i_trigger_return && i_total != 0) || m_wait == WAIT) begin
                    m_rem   = longint'(i_total);
                    m_short = 0;
                    m_wait  = 0;
                    m_phase = 1;
                end else if (i_input_coin != 0 || i_item_dispensed) begin
                    m_wait = 0;
                end else if (i_total != 0 && m_wait < WAIT) begin
                    m_wait = m_wait + 1;
                end
            end
            for (int j = 0; j < NC; j++) begin
                if (i_input_coin[j] && m_coin[j]) begin
                end else if (i_input_coin[j]) begin
                    if (m_inv[j] < 255) m_inv[j] = m_inv[j] + 1;
                end else if (m_coin[j]) begin
                    m_inv[j] = m_inv[j] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("coin",      longint'(o_return_coin), longint'(m_coin));
            chk("busy",      longint'(o_busy), (m_phase == 1) ? 1 : 0);
            chk("done",      longint'(o_done), (m_phase == 2) ? 1 : 0);
            chk("shortfall", longint'(o_shortfall), m_short);
            chk("wait_time", longint'(o_wait_time), longint'(m_wait));
            for (int j = 0; j < NC; j++)
                chk("inventory", longint'(o_inventory[j*IB +: IB]), longint'(m_inv[j]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    logic [NC-1:0] obs [$];
    int            done_at;

    task automatic payout(input logic [TB-1:0] total);
        i_total          = total;
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_total          = '0;
        obs.delete();
        done_at = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (o_done) begin
                done_at = c;
                break;
            end
            obs.push_back(o_return_coin);
        end
        if (done_at < 0) chk("payout_done_timeout", done_at, 0);
    endtask

    initial begin
        int cnt;
        int wait_seen;
        reset_n          = 1'b0;
        i_input_coin     = '0;
        i_item_dispensed = 1'b0;
        i_trigger_return = 1'b0;
        i_total          = '0;
        tick();
        tick();
        chk("reset_inventory", longint'(o_inventory), longint'(24'h040404));
        chk("reset_busy", longint'(o_busy), 0);
        chk("reset_wait", longint'(o_wait_time), 0);
        reset_n = 1'b1;
        tick();

        // Greedy 1700 = 1000 + 500 + 100 + 100
        payout(31'd1700);
        chk("g_ncoins", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("g_coin0", longint'(obs[0]), 4);
            chk("g_coin1", longint'(obs[1]), 2);
            chk("g_coin2", longint'(obs[2]), 1);
            chk("g_coin3", longint'(obs[3]), 1);
        end
        chk("g_done_cycle", done_at, 5);
        chk("g_shortfall", longint'(o_shortfall), 0);
        chk("g_inventory", longint'(o_inventory), longint'(24'h030302));
        tick();

        // Empty the 1000 slot, then 1000 must fall back to two 500s
        payout(31'd3000);
        chk("drain_done_cycle", done_at, 4);
        tick();
        payout(31'd1000);
        chk("fb_ncoins", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("fb_coin0", longint'(obs[0]), 2);
            chk("fb_coin1", longint'(obs[1]), 2);
        end
        chk("fb_shortfall", longint'(o_shortfall), 0);
        chk("fb_inventory", longint'(o_inventory), longint'(24'h000102));
        tick();

        // Reduce to {0,0,1}, then 350 can only pay one 100
        payout(31'd600);
        chk("sf_prep_inventory", longint'(o_inventory), longint'(24'h000001));
        tick();
        payout(31'd350);
        chk("sf_ncoins", obs.size(), 1);
        if (obs.size() == 1) chk("sf_coin0", longint'(obs[0]), 1);
        chk("sf_done_cycle", done_at, 2);
        chk("sf_shortfall", longint'(o_shortfall), 250);
        tick();
        chk("sf_shortfall_held", longint'(o_shortfall), 250);

        // Deposit and payout of the same 500 coin in one cycle
        i_input_coin = 3'b010;
        tick();
        tick();
        i_input_coin = '0;
        chk("cc_prep_inv1", longint'(o_inventory[IB +: IB]), 2);
        i_total          = 31'd500;
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_total          = '0;
        chk("cc_shortfall_cleared", longint'(o_shortfall), 0);
        i_input_coin = 3'b010;
        tick();
        i_input_coin = '0;
        chk("cc_coin", longint'(o_return_coin), 2);
        chk("cc_inv1", longint'(o_inventory[IB +: IB]), 2);
        tick();
        chk("cc_done", longint'(o_done), 1);
        tick();

        // Saturate the 100 counter
        for (int i = 0; i < 256; i++) begin
            i_input_coin = 3'b001;
            tick();
        end
        i_input_coin = '0;
        chk("sat_inv0", longint'(o_inventory[IB-1:0]), 255);

        // Trigger with zero balance is ignored
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        chk("zero_trig_busy", longint'(o_busy), 0);
        tick();
        chk("zero_trig_busy2", longint'(o_busy), 0);

        // Inactivity timeout, with item and deposit restarts
        i_total = 31'd500;
        repeat (5) tick();
        chk("to_wait5", longint'(o_wait_time), 5);
        i_item_dispensed = 1'b1;
        tick();
        i_item_dispensed = 1'b0;
        chk("to_item_clear", longint'(o_wait_time), 0);
        repeat (60) tick();
        chk("to_wait60", longint'(o_wait_time), 60);
        i_input_coin = 3'b001;
        tick();
        i_input_coin = '0;
        chk("to_deposit_clear", longint'(o_wait_time), 0);
        cnt       = -1;
        wait_seen = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == 100) wait_seen = int'(o_wait_time);
            if (o_busy) begin
                cnt = c;
                break;
            end
        end
        i_total = '0;
        chk("to_wait_at_100", wait_seen, 100);
        chk("to_start_cycle", cnt, 101);
        tick();
        chk("to_coin", longint'(o_return_coin), 2);
        tick();
        chk("to_done", longint'(o_done), 1);
        tick();

        // Reset in the middle of a payout
        i_total          = 31'd1700;
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        i_total          = '0;
        tick();
        chk("rst_first_coin", longint'(o_return_coin), 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_busy", longint'(o_busy), 0);
        chk("rst_coin", longint'(o_return_coin), 0);
        chk("rst_done", longint'(o_done), 0);
        chk("rst_inventory", longint'(o_inventory), longint'(24'h040404));
        repeat (3) begin
            tick();
            chk("rst_no_coin", longint'(o_return_coin), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Parametrised successor to the vending machine's coin-return/timeout checker.
- Owns a per-denomination coin inventory and the inactivity timer.
- On a return trigger or timeout, latches the outstanding balance and pays it out greedily, one coin per cycle, limited by inventory.
- Sits between the coin-input front end and the balance/item controller; reports completion and any unpayable shortfall.

Parameters:
- NUM_COINS, 3, number of coin denominations.
- TOTAL_BITS, 31, width of the balance.
- INV_BITS, 8, width of each inventory counter.
- WAIT_TIME, 100, idle cycles before an automatic return.
- COIN_VALUES, {32'd1000,32'd500,32'd100}, packed NUM_COINS×32 denomination values; index 0 is the smallest; values strictly ascending.
- INIT_INV, {NUM_COINS{8'd4}}, packed NUM_COINS×INV_BITS reset inventory.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_input_coin  in  NUM_COINS  one-hot deposit pulse; one cycle per coin
- i_item_dispensed  in  1  pulse; an item was dispensed
- i_trigger_return  in  1  pulse; user requests change
- i_total  in  TOTAL_BITS  current balance from the item controller
- o_return_coin  out  NUM_COINS  one-hot; one coin ejected this cycle
- o_busy  out  1  high in RETURN
- o_done  out  1  one-cycle pulse when payout ends
- o_shortfall  out  TOTAL_BITS  unpaid remainder, valid with o_done, held until the next start
- o_wait_time  out  32  idle counter
- o_inventory  out  NUM_COINS*INV_BITS  packed inventory counts

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - state IDLE; o_return_coin=0; o_busy=0; o_done=0; o_shortfall=0; o_wait_time=0; inventory=INIT_INV.
  - Reset mid-RETURN aborts immediately; no further coins.
- States: IDLE, RETURN, DONE.
- IDLE:
  - o_wait_time clears to 0 on any i_input_coin bit or i_item_dispensed.
  - Otherwise it increments while i_total>0, and holds when i_total==0.
  - Start condition: (i_trigger_return && i_total>0) || o_wait_time==WAIT_TIME.
  - On start: latch remaining<=i_total, clear o_shortfall, go to RETURN.
  - A trigger with i_total==0 is ignored.
  - o_wait_time saturates at WAIT_TIME.
- RETURN:
  - Each cycle select the highest index k with COIN_VALUES[k] <= remaining and inventory[k] > 0.
  - If a k exists, assert o_return_coin[k] (registered, one-hot), remaining -= COIN_VALUES[k], inventory[k] -= 1.
  - If remaining==0, go to DONE with o_shortfall=0.
  - If remaining>0 and no coin qualifies, go to DONE with o_shortfall=remaining.
  - o_wait_time is held at 0.
  - i_trigger_return is ignored.
- DONE: o_done pulses for one cycle, o_return_coin=0, then go to IDLE with o_wait_time=0.
- Output latency: the first coin appears the cycle after the start edge. A balance paid with N coins yields o_done on cycle N+1 after start.
- Inventory:
  - A deposit increments inventory[j] in any state.
  - Deposit and payout of the same denomination in one cycle leaves the net count unchanged.
  - Increment saturates at 2^INV_BITS-1. The coin is still accepted upstream; the saturation is not flagged.
- The upstream controller decrements its balance per o_return_coin pulse. This block never reads i_total during RETURN.
- Arithmetic:
  - Compare remaining against COIN_VALUES zero-extended to max(TOTAL_BITS,32).
  - Subtraction never underflows, because it is guarded by the compare.
- i_input_coin with more than one bit set is a protocol error; every set bit is counted.

Decomposition:
- Shared package vending_machine_pkg:
  - kNumCoins, kTotalBits, kWaitTime, default coin values, state enum type.
  - Replaces the existing `define header for new code.
- One natural sub-module: coin_select, a combinational priority picker.
  - Inputs: remaining, inventory, COIN_VALUES.
  - Outputs: one-hot select and found flag.

Test Plan:
- Greedy payout: INIT_INV=4 each, i_total=1700, pulse i_trigger_return.
  - o_return_coin = 100, 010, 001, 001 over four cycles.
  - o_done on cycle 5; o_shortfall=0; inventory = {3,3,2}.
- Inventory-limited fallback: inventory[2]=0, i_total=1000, trigger.
  - Two 500 coins, then o_done with o_shortfall=0; inventory[1] drops by 2.
- Shortfall: inventory={0,0,1}, i_total=350, trigger.
  - One 100 coin, then o_done with o_shortfall=250.
- Timeout: i_total=500, no activity, WAIT_TIME=100.
  - RETURN entered when o_wait_time==100; one coin 010 emitted.
  - A coin deposit at cycle 60 restarts the count, so the timeout occurs 100 cycles after the deposit.
- Concurrency and saturation:
  - Deposit 010 on the same cycle 010 is paid: inventory[1] unchanged.
  - Deposit at count 255 stays 255.
  - Trigger with i_total=0: no state change.
- Reset mid-RETURN: assert reset_n=0 after the first coin of a 1700 payout.
  - Next cycle: IDLE, o_return_coin=0, inventory=INIT_INV, no o_done.
